mem_port_arbiter: RTL

//   Shares one single-ported backing memory bus between the pipeline's fetch requester (IF, read-only)
//   and data requester (MEM, read/write). One transaction outstanding at a time.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_grant.sv | 30 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
// MEM_ARB_ROUND_ROBIN_EN (optional) switches grant selection to round-robin.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant select between fetch and data requesters.
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise MEM has fixed priority.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   mem_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  owner_t last_owner,
`endif
    output owner_t grant
);

    always_comb begin
        grant = OWN_NONE;
        if (if_req && mem_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant = (last_owner == OWN_MEM) ? OWN_IF : OWN_MEM;
`else
            // Data access belongs to the older instruction, so it goes first.
            grant = OWN_MEM;
`endif
        end else if (mem_req) begin
            grant = OWN_MEM;
        end else if (if_req) begin
            grant = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between fetch (IF) and data (MEM) requesters.
// Optional MEM_ARB_ROUND_ROBIN_EN adds a last_owner register for fair contention.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_stall,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    state_t state, state_n;
    owner_t owner, grant;
    logic   abandoned;
    logic   mem_req;
    logic   owner_req;

    assign mem_req   = mem_rd_req || mem_wr_req;
    assign if_stall  = if_req && !if_done;
    assign mem_stall = mem_req && !mem_done;
    assign busy      = (state != IDLE);
    assign owner_req = (owner == OWN_IF) ? if_req : ((owner == OWN_MEM) ? mem_req : 1'b0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t last_owner;
`endif

    // A requester whose done is showing is still holding the finished request; mask it.
    mem_arb_grant u_grant (
        .if_req     (if_req && !if_done),
        .mem_req    (mem_req && !mem_done),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner (last_owner),
`endif
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (grant != OWN_NONE) state_n = REQ;
            REQ:     if (bus_ready)         state_n = WAIT;
            WAIT:    if (bus_rvalid)        state_n = IDLE;
            default:                        state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner     <= OWN_NONE;
            abandoned <= 1'b0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner <= OWN_MEM;
`endif
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != OWN_NONE) begin
                        owner     <= grant;
                        abandoned <= 1'b0;
                        bus_valid <= 1'b1;
                        bus_addr  <= (grant == OWN_MEM) ? mem_addr : if_addr;
                        bus_we    <= (grant == OWN_MEM) && mem_wr_req;
                        bus_wdata <= (grant == OWN_MEM) ? mem_wdata : '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_owner <= grant;
`endif
                    end
                end
                REQ: begin
                    if (!owner_req) abandoned <= 1'b1;
                    if (bus_ready)  bus_valid <= 1'b0;
                end
                WAIT: begin
                    // A flushed owner still lets the bus transaction finish, but sees nothing.
                    if (bus_rvalid) begin
                        owner <= OWN_NONE;
                        if (owner_req && !abandoned) begin
                            if (owner == OWN_IF) begin
                                if_rdata <= bus_rdata;
                                if_done  <= 1'b1;
                            end else if (owner == OWN_MEM) begin
                                if (!bus_we) mem_rdata <= bus_rdata;
                                mem_done <= 1'b1;
                            end
                        end
                    end else if (!owner_req) begin
                        abandoned <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
